// File: rtl/lvds_tx_pll_ctrl_if.sv
// Divider reconfiguration handshake for the LVDS TX PLL controller.
// Host (master) offers codes with cfg_valid; controller (slave) takes them on cfg_ready.
interface lvds_tx_pll_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_idiv;
  logic [5:0] cfg_fbdiv;
  logic [5:0] cfg_odiv;

  modport master (
    output cfg_valid,
    output cfg_idiv,
    output cfg_fbdiv,
    output cfg_odiv,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_idiv,
    input  cfg_fbdiv,
    input  cfg_odiv,
    output cfg_ready
  );
endinterface

// File: rtl/lvds_tx_pll_ctrl.sv
// LVDS TX rPLL supervisor: drives PLL reset/divider selects, qualifies lock with retry.
// Ports: clkin/reset, async pll_lock, cfg (slave handshake), PLL controls, tx_rst/run/fail, lock_loss_cnt.
module lvds_tx_pll_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRY    = 3,
  parameter int DEF_IDIV     = 1,
  parameter int DEF_FBDIV    = 6,
  parameter int DEF_ODIV     = 1,
  parameter int CNT_W        = 8
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             pll_lock,
  lvds_tx_pll_ctrl_if.slave cfg,
  output logic             pll_reset,
  output logic [5:0]       pll_idsel,
  output logic [5:0]       pll_fbdsel,
  output logic [5:0]       pll_odsel,
  output logic             tx_rst,
  output logic             run,
  output logic             fail,
  output logic [CNT_W-1:0] lock_loss_cnt
);

  localparam logic [2:0] ST_APPLY  = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_FAIL   = 3'd4;

  localparam int TMAX_A =
    (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int TMAX =
    (TMAX_A > LOCK_STABLE) ? TMAX_A : LOCK_STABLE;
  localparam int TW = $clog2(TMAX + 1);
  localparam int RW =
    (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(LOCK_STABLE - 1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);

  localparam logic [5:0] D_ID = 6'(DEF_IDIV);
  localparam logic [5:0] D_FB = 6'(DEF_FBDIV);
  localparam logic [5:0] D_OD = 6'(DEF_ODIV);

  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             sync1_q, sync1_d;
  logic             lock_s_q, lock_s_d;
  logic [5:0]       idiv_q, idiv_d;
  logic [5:0]       fbdiv_q, fbdiv_d;
  logic [5:0]       odiv_q, odiv_d;
  logic [5:0]       idsel_q, idsel_d;
  logic [5:0]       fbdsel_q, fbdsel_d;
  logic [5:0]       odsel_q, odsel_d;
  logic             pll_reset_q, pll_reset_d;
  logic             tx_rst_q, tx_rst_d;
  logic             run_q, run_d;
  logic             fail_q, fail_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] loss_q, loss_d;

  logic accept;
  logic retry_now;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    retry_d   = retry_q;
    idiv_d    = idiv_q;
    fbdiv_d   = fbdiv_q;
    odiv_d    = odiv_q;
    idsel_d   = idsel_q;
    fbdsel_d  = fbdsel_q;
    odsel_d   = odsel_q;
    loss_d    = loss_q;
    retry_now = 1'b0;
    sync1_d   = pll_lock;
    lock_s_d  = sync1_q;
    accept    = cfg.cfg_valid & ready_q;

    unique case (state_q)
      ST_APPLY: begin
        tmr_d = tmr_q + TW'(1);
        if (tmr_q == RST_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tmr_d = tmr_q + TW'(1);
        if (lock_s_q) state_d = ST_SETTLE;
        else if (tmr_q == TO_LAST) retry_now = 1'b1;
      end
      ST_SETTLE: begin
        tmr_d = tmr_q + TW'(1);
        if (!lock_s_q) retry_now = 1'b1;
        else if (tmr_q == STB_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          state_d = ST_APPLY;
          retry_d = '0;
          if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
        end
      end
      ST_FAIL: begin
      end
      default: state_d = ST_APPLY;
    endcase

    if (retry_now) begin
      if (retry_q < RTY_MAX) begin
        retry_d = retry_q + RW'(1);
        state_d = ST_APPLY;
      end else begin
        state_d = ST_FAIL;
      end
    end

    // Accept overrides lock-loss state change but keeps its loss count.
    if (accept) begin
      idiv_d  = cfg.cfg_idiv;
      fbdiv_d = cfg.cfg_fbdiv;
      odiv_d  = cfg.cfg_odiv;
      retry_d = '0;
      state_d = ST_APPLY;
    end

    if (state_d != state_q) tmr_d = '0;

    // Selects only move while the PLL is being held in reset.
    if (state_d == ST_APPLY && state_q != ST_APPLY) begin
      idsel_d  = ~idiv_d;
      fbdsel_d = ~fbdiv_d;
      odsel_d  = ~odiv_d;
    end

    pll_reset_d = (state_d == ST_APPLY);
    tx_rst_d    = (state_d != ST_RUN);
    run_d       = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
    ready_d     = (state_d == ST_RUN) || (state_d == ST_FAIL);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= ST_APPLY;
      tmr_q       <= '0;
      retry_q     <= '0;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      idiv_q      <= D_ID;
      fbdiv_q     <= D_FB;
      odiv_q      <= D_OD;
      idsel_q     <= ~D_ID;
      fbdsel_q    <= ~D_FB;
      odsel_q     <= ~D_OD;
      pll_reset_q <= 1'b1;
      tx_rst_q    <= 1'b1;
      run_q       <= 1'b0;
      fail_q      <= 1'b0;
      ready_q     <= 1'b0;
      loss_q      <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      retry_q     <= retry_d;
      sync1_q     <= sync1_d;
      lock_s_q    <= lock_s_d;
      idiv_q      <= idiv_d;
      fbdiv_q     <= fbdiv_d;
      odiv_q      <= odiv_d;
      idsel_q     <= idsel_d;
      fbdsel_q    <= fbdsel_d;
      odsel_q     <= odsel_d;
      pll_reset_q <= pll_reset_d;
      tx_rst_q    <= tx_rst_d;
      run_q       <= run_d;
      fail_q      <= fail_d;
      ready_q     <= ready_d;
      loss_q      <= loss_d;
    end
  end

  assign cfg.cfg_ready  = ready_q;
  assign pll_reset      = pll_reset_q;
  assign pll_idsel      = idsel_q;
  assign pll_fbdsel     = fbdsel_q;
  assign pll_odsel      = odsel_q;
  assign tx_rst         = tx_rst_q;
  assign run            = run_q;
  assign fail           = fail_q;
  assign lock_loss_cnt  = loss_q;

endmodule

// File: tb/tb_lvds_tx_pll_ctrl.sv
// Bench for lvds_tx_pll_ctrl: expected output changes (cycle + value) are queued
// by the stimulus; a negedge monitor pops one per observed output change.
module tb_lvds_tx_pll_ctrl;

  typedef struct packed {
    logic       pr;
    logic       tx;
    logic       run;
    logic       fail;
    logic       rdy;
    logic [5:0] id;
    logic [5:0] fb;
    logic [5:0] od;
    logic [1:0] cnt;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel;
  logic [5:0] pll_fbdsel;
  logic [5:0] pll_odsel;
  logic       tx_rst;
  logic       run;
  logic       fail;
  logic [1:0] lock_loss_cnt;

  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  bit    mon_en = 1'b0;
  ev_t   q[$];
  snap_t m;
  snap_t prev;

  lvds_tx_pll_ctrl_if cfg_if ();

  lvds_tx_pll_ctrl #(
    .RST_CYCLES   (16),
    .LOCK_TIMEOUT (300),
    .LOCK_STABLE  (1024),
    .MAX_RETRY    (3),
    .DEF_IDIV     (1),
    .DEF_FBDIV    (6),
    .DEF_ODIV     (1),
    .CNT_W        (2)
  ) dut (
    .clkin         (clk),
    .reset         (reset),
    .pll_lock      (pll_lock),
    .cfg           (cfg_if),
    .pll_reset     (pll_reset),
    .pll_idsel     (pll_idsel),
    .pll_fbdsel    (pll_fbdsel),
    .pll_odsel     (pll_odsel),
    .tx_rst        (tx_rst),
    .run           (run),
    .fail          (fail),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic snap_t dut_snap();
    snap_t s;
    s.pr   = pll_reset;
    s.tx   = tx_rst;
    s.run  = run;
    s.fail = fail;
    s.rdy  = cfg_if.cfg_ready;
    s.id   = pll_idsel;
    s.fb   = pll_fbdsel;
    s.od   = pll_odsel;
    s.cnt  = lock_loss_cnt;
    return s;
  endfunction

  // Monitor: every change of the output tuple is one comparison.
  always @(negedge clk) begin
    snap_t s;
    ev_t   e;
    if (mon_en) begin
      s = dut_snap();
      if (s !== prev) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected change: cyc=%0d out=%h", cyc, s);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.s !== s) begin
            n_bad++;
            $display("FAIL ev: got cyc=%0d out=%h, want cyc=%0d out=%h",
                     cyc, s, e.cyc, e.s);
          end
        end
        prev = s;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic push(input int at);
    ev_t e;
    e.cyc = at;
    e.s   = m;
    q.push_back(e);
  endtask

  task automatic set_apply();
    m.pr = 1'b1; m.tx = 1'b1; m.run = 1'b0;
    m.fail = 1'b0; m.rdy = 1'b0;
  endtask

  task automatic set_run();
    m.pr = 1'b0; m.tx = 1'b0; m.run = 1'b1;
    m.fail = 1'b0; m.rdy = 1'b1;
  endtask

  task automatic set_fail();
    m.pr = 1'b0; m.tx = 1'b1; m.run = 1'b0;
    m.fail = 1'b1; m.rdy = 1'b1;
  endtask

  task automatic set_sel(input logic [5:0] i,
                         input logic [5:0] f,
                         input logic [5:0] o);
    m.id = ~i; m.fb = ~f; m.od = ~o;
  endtask

  task automatic drive_cfg(input logic v,
                           input logic [5:0] i,
                           input logic [5:0] f,
                           input logic [5:0] o);
    cfg_if.cfg_valid = v;
    cfg_if.cfg_idiv  = i;
    cfg_if.cfg_fbdiv = f;
    cfg_if.cfg_odiv  = o;
  endtask

  initial begin
    int c;
    int a;
    reset    = 1'b1;
    pll_lock = 1'b0;
    drive_cfg(1'b0, 6'd0, 6'd0, 6'd0);
    prev     = 'x;

    // Reset state
    step(3);
    c = cyc;
    set_apply();
    set_sel(6'd1, 6'd6, 6'd1);
    m.cnt = 2'd0;
    push(c);
    mon_en = 1'b1;
    reset  = 1'b0;

    // T1: 16-cycle PLL reset, lock 100 cycles later, RUN 1026 after
    m.pr = 1'b0;
    push(c + 16);
    step(116);
    pll_lock = 1'b1;
    c = cyc;
    set_run();
    push(c + 1 + 1026);
    wait_until(c + 1030);

    // T3: five 3-cycle lock glitches, loss counter saturates at 3
    for (int k = 1; k <= 5; k++) begin
      c = cyc;
      pll_lock = 1'b0;
      set_apply();
      m.cnt = (k > 3) ? 2'd3 : 2'(k);
      push(c + 3);
      m.pr = 1'b0;
      push(c + 19);
      set_run();
      push(c + 1044);
      step(3);
      pll_lock = 1'b1;
      wait_until(c + 1050);
    end

    // T4: reconfigure in RUN, idiv=0 fbdiv=9 odiv=3
    c = cyc;
    drive_cfg(1'b1, 6'd0, 6'd9, 6'd3);
    set_apply();
    set_sel(6'd0, 6'd9, 6'd3);
    push(c + 1);
    m.pr = 1'b0;
    push(c + 17);
    set_run();
    push(c + 1042);
    step(1);
    drive_cfg(1'b0, 6'd0, 6'd0, 6'd0);
    wait_until(c + 1048);

    // T6a: reset during SETTLE restores defaults and clears count
    c = cyc;
    pll_lock = 1'b0;
    set_apply();
    push(c + 3);
    m.pr = 1'b0;
    push(c + 19);
    step(3);
    pll_lock = 1'b1;
    wait_until(c + 50);
    reset = 1'b1;
    set_apply();
    set_sel(6'd1, 6'd6, 6'd1);
    m.cnt = 2'd0;
    push(c + 51);
    m.pr = 1'b0;
    push(c + 67);
    set_run();
    push(c + 1092);
    step(1);
    reset = 1'b0;
    wait_until(c + 1098);

    // T6b: reset coincident with a config offer discards the config
    c = cyc;
    reset = 1'b1;
    drive_cfg(1'b1, 6'd5, 6'd7, 6'd2);
    set_apply();
    push(c + 1);
    m.pr = 1'b0;
    push(c + 17);
    set_run();
    push(c + 1042);
    step(1);
    reset = 1'b0;
    drive_cfg(1'b0, 6'd0, 6'd0, 6'd0);
    wait_until(c + 1048);

    // T2: lock tied low, four attempts then FAIL
    c = cyc;
    reset    = 1'b1;
    pll_lock = 1'b0;
    a = c + 1;
    set_apply();
    push(a);
    for (int i = 0; i < 4; i++) begin
      m.pr = 1'b0;
      push(a + 16 + 316 * i);
      if (i < 3) begin
        m.pr = 1'b1;
        push(a + 316 * (i + 1));
      end
    end
    set_fail();
    push(a + 1264);
    step(1);
    reset = 1'b0;
    // Offer outside RUN/FAIL must be ignored
    step(100);
    drive_cfg(1'b1, 6'h11, 6'h22, 6'h33);
    step(5);
    drive_cfg(1'b0, 6'd0, 6'd0, 6'd0);
    wait_until(a + 1270);

    // T5: accept in FAIL clears retry; one retry then lock
    c = cyc;
    drive_cfg(1'b1, 6'd2, 6'd4, 6'd1);
    set_apply();
    set_sel(6'd2, 6'd4, 6'd1);
    push(c + 1);
    m.pr = 1'b0;
    push(c + 17);
    m.pr = 1'b1;
    push(c + 317);
    m.pr = 1'b0;
    push(c + 333);
    step(1);
    drive_cfg(1'b0, 6'd0, 6'd0, 6'd0);
    wait_until(c + 400);
    pll_lock = 1'b1;
    set_run();
    push(c + 401 + 1026);
    wait_until(c + 1435);

    step(20);
    while (q.size() > 0) begin
      ev_t e;
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing: want cyc=%0d out=%h", e.cyc, e.s);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
